// File: rtl/load_unit_ctrl_if.sv
// Data-memory read bus between the load sequencer (master) and the memory port (slave).
interface load_unit_ctrl_if;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  modport master (output mem_req, mem_addr, input mem_gnt, mem_rvalid, mem_rdata);
  modport slave  (input mem_req, mem_addr, output mem_gnt, mem_rvalid, mem_rdata);
endinterface

// File: rtl/load_unit_ctrl.sv
// Multi-cycle load sequencer: computes the effective address, runs one memory read
// transaction, then aligns/extends the data into a writeback or reports a fault.
module load_unit_ctrl #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  output logic                    ready,
  input  logic [4:0]              op,
  input  logic [31:0]             base,
  input  logic [11:0]             imm,
  input  logic [4:0]              rd,
  load_unit_ctrl_if.master        mem,
  output logic                    wb_valid,
  output logic [4:0]              wb_rd,
  output logic [31:0]             wb_data,
  output logic                    fault_valid,
  output logic [1:0]              fault_cause,
  output logic [31:0]             fault_addr
);

  // Load op encodings shared with the decoder.
  localparam logic [4:0] LD_NOP = 5'd0;
  localparam logic [4:0] LB     = 5'd1;
  localparam logic [4:0] LH     = 5'd2;
  localparam logic [4:0] LW     = 5'd3;
  localparam logic [4:0] LBU    = 5'd4;
  localparam logic [4:0] LHU    = 5'd5;

  localparam logic [15:0] LAST = 16'(TIMEOUT - 1);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_WB, S_ERR} state_t;

  state_t      state, next_state;
  logic [31:0] ea, ea_q;
  logic [4:0]  op_q, rd_q;
  logic [15:0] cnt;
  logic [1:0]  cause_q;
  logic        op_valid, aligned;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_result;

  assign ea = base + {{20{imm[11]}}, imm};

  always_comb begin
    op_valid = (op == LB) || (op == LH) || (op == LW) || (op == LBU) || (op == LHU);
    case (op)
      LH, LHU: aligned = ~ea[0];
      LW:      aligned = (ea[1:0] == 2'b00);
      default: aligned = 1'b1;
    endcase
  end

  always_comb begin
    case (ea_q[1:0])
      2'd0:    byte_sel = mem.mem_rdata[7:0];
      2'd1:    byte_sel = mem.mem_rdata[15:8];
      2'd2:    byte_sel = mem.mem_rdata[23:16];
      default: byte_sel = mem.mem_rdata[31:24];
    endcase
    half_sel = ea_q[1] ? mem.mem_rdata[31:16] : mem.mem_rdata[15:0];
    case (op_q)
      LB:      load_result = {{24{byte_sel[7]}}, byte_sel};
      LBU:     load_result = {24'd0, byte_sel};
      LH:      load_result = {{16{half_sel[15]}}, half_sel};
      LHU:     load_result = {16'd0, half_sel};
      default: load_result = mem.mem_rdata;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: if (start && op_valid) next_state = aligned ? S_REQ : S_ERR;
      S_REQ:  if (mem.mem_gnt) next_state = S_WAIT;
      S_WAIT: begin
        if (mem.mem_rvalid)   next_state = S_WB;
        else if (cnt == LAST) next_state = S_ERR;
      end
      S_WB:    next_state = S_IDLE;
      S_ERR:   next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // Writeback registers only change on a real (rd != 0) writeback so they hold between strobes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ea_q    <= '0;
      op_q    <= LD_NOP;
      rd_q    <= '0;
      cnt     <= '0;
      cause_q <= '0;
      wb_rd   <= '0;
      wb_data <= '0;
    end else begin
      case (state)
        S_IDLE: if (start && op_valid) begin
          ea_q    <= ea;
          op_q    <= op;
          rd_q    <= rd;
          cause_q <= aligned ? 2'b00 : 2'b01;
        end
        S_REQ: if (mem.mem_gnt) cnt <= '0;
        S_WAIT: begin
          if (mem.mem_rvalid) begin
            if (rd_q != 5'd0) begin
              wb_rd   <= rd_q;
              wb_data <= load_result;
            end
          end else if (cnt == LAST) begin
            cause_q <= 2'b10;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    ready        = (state == S_IDLE);
    mem.mem_req  = (state == S_REQ);
    mem.mem_addr = (state == S_REQ) ? {ea_q[31:2], 2'b00} : 32'd0;
    wb_valid     = (state == S_WB) && (rd_q != 5'd0);
    fault_valid  = (state == S_ERR);
    fault_cause  = (state == S_ERR) ? cause_q : 2'b00;
    fault_addr   = (state == S_ERR) ? ea_q : 32'd0;
  end

endmodule

// File: tb/tb_load_unit_ctrl.sv
// Directed bench for load_unit_ctrl: fast loads, extraction, misalignment, timeout, x0 and reset abandon.
module tb_load_unit_ctrl;

  localparam logic [4:0] LD_NOP = 5'd0;
  localparam logic [4:0] LB     = 5'd1;
  localparam logic [4:0] LH     = 5'd2;
  localparam logic [4:0] LW     = 5'd3;
  localparam logic [4:0] LBU    = 5'd4;
  localparam logic [4:0] LHU    = 5'd5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        ready;
  logic [4:0]  op = '0;
  logic [31:0] base = '0;
  logic [11:0] imm = '0;
  logic [4:0]  rd = '0;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        fault_valid;
  logic [1:0]  fault_cause;
  logic [31:0] fault_addr;

  int checks = 0;
  int passed = 0;
  int failed = 0;

  load_unit_ctrl_if bus ();

  load_unit_ctrl #(.TIMEOUT(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .ready       (ready),
    .op          (op),
    .base        (base),
    .imm         (imm),
    .rd          (rd),
    .mem         (bus.master),
    .wb_valid    (wb_valid),
    .wb_rd       (wb_rd),
    .wb_data     (wb_data),
    .fault_valid (fault_valid),
    .fault_cause (fault_cause),
    .fault_addr  (fault_addr)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Presents one load for a single accepting edge; returns in cycle 1.
  task automatic applyStimulus(input logic [4:0] o, input logic [31:0] b,
                               input logic [11:0] i, input logic [4:0] r);
    op = o; base = b; imm = i; rd = r; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Zero-wait-state load: grant in cycle 1, data in cycle 2; returns in cycle 3 (WB).
  task automatic fastLoad(input string tag, input logic [4:0] o, input logic [31:0] b,
                          input logic [11:0] i, input logic [4:0] r,
                          input logic [31:0] rdata, input logic [31:0] exp_addr);
    applyStimulus(o, b, i, r);
    checkOutput({tag, "_req"}, 32'(bus.mem_req), 32'd1);
    checkOutput({tag, "_addr"}, bus.mem_addr, exp_addr);
    bus.mem_gnt = 1'b1;
    tick();
    bus.mem_gnt = 1'b0;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata = rdata;
    tick();
    bus.mem_rvalid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bus.mem_gnt = 1'b0;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata = '0;

    #2;
    checkOutput("rst_ready",   32'(ready), 32'd1);
    checkOutput("rst_req",     32'(bus.mem_req), 32'd0);
    checkOutput("rst_addr",    bus.mem_addr, 32'd0);
    checkOutput("rst_wbv",     32'(wb_valid), 32'd0);
    checkOutput("rst_wbrd",    32'(wb_rd), 32'd0);
    checkOutput("rst_wbdata",  wb_data, 32'd0);
    checkOutput("rst_fv",      32'(fault_valid), 32'd0);
    checkOutput("rst_fcause",  32'(fault_cause), 32'd0);
    checkOutput("rst_faddr",   fault_addr, 32'd0);
    #10 rst = 1'b0;
    tick();

    // LW 0x1000+4, minimum latency path
    applyStimulus(LW, 32'h1000, 12'h004, 5'd5);
    checkOutput("lw_c1_req",   32'(bus.mem_req), 32'd1);
    checkOutput("lw_c1_addr",  bus.mem_addr, 32'h1004);
    checkOutput("lw_c1_ready", 32'(ready), 32'd0);
    bus.mem_gnt = 1'b1;
    tick();
    bus.mem_gnt = 1'b0;
    checkOutput("lw_c2_req",   32'(bus.mem_req), 32'd0);
    checkOutput("lw_c2_addr",  bus.mem_addr, 32'd0);
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata = 32'hDEADBEEF;
    tick();
    bus.mem_rvalid = 1'b0;
    checkOutput("lw_c3_wbv",   32'(wb_valid), 32'd1);
    checkOutput("lw_c3_data",  wb_data, 32'hDEADBEEF);
    checkOutput("lw_c3_rd",    32'(wb_rd), 32'd5);
    checkOutput("lw_c3_ready", 32'(ready), 32'd0);
    tick();
    checkOutput("lw_c4_ready", 32'(ready), 32'd1);
    checkOutput("lw_c4_wbv",   32'(wb_valid), 32'd0);
    checkOutput("lw_c4_hold",  wb_data, 32'hDEADBEEF);

    // Byte/halfword extraction
    fastLoad("lb", LB, 32'h2000, 12'h003, 5'd1, 32'h80112233, 32'h2000);
    checkOutput("lb_data", wb_data, 32'hFFFFFF80);
    checkOutput("lb_rd",   32'(wb_rd), 32'd1);
    tick();
    fastLoad("lbu", LBU, 32'h2000, 12'h003, 5'd2, 32'h80112233, 32'h2000);
    checkOutput("lbu_data", wb_data, 32'h00000080);
    tick();
    fastLoad("lhu", LHU, 32'h2000, 12'h002, 5'd3, 32'h80112233, 32'h2000);
    checkOutput("lhu_data", wb_data, 32'h00008011);
    tick();
    fastLoad("lh", LH, 32'h2000, 12'h000, 5'd4, 32'h80118765, 32'h2000);
    checkOutput("lh_data", wb_data, 32'hFFFF8765);
    tick();
    fastLoad("lbmid", LB, 32'h2000, 12'h001, 5'd6, 32'h80117F33, 32'h2000);
    checkOutput("lbmid_data", wb_data, 32'h0000007F);
    tick();
    // Negative immediate and address wrap-around
    fastLoad("lwneg", LW, 32'h1000, 12'hFFC, 5'd7, 32'h01234567, 32'h00000FFC);
    checkOutput("lwneg_data", wb_data, 32'h01234567);
    tick();
    fastLoad("wrap", LBU, 32'hFFFFFFFC, 12'h008, 5'd8, 32'h000000A5, 32'h00000004);
    checkOutput("wrap_data", wb_data, 32'h000000A5);
    tick();

    // Misaligned LH at 0xFFFFFFFF
    applyStimulus(LH, 32'h0, 12'hFFF, 5'd3);
    checkOutput("mis_fv",     32'(fault_valid), 32'd1);
    checkOutput("mis_cause",  32'(fault_cause), 32'd1);
    checkOutput("mis_addr",   fault_addr, 32'hFFFFFFFF);
    checkOutput("mis_req",    32'(bus.mem_req), 32'd0);
    checkOutput("mis_ready",  32'(ready), 32'd0);
    tick();
    checkOutput("mis_ready2", 32'(ready), 32'd1);
    checkOutput("mis_fv2",    32'(fault_valid), 32'd0);
    checkOutput("mis_cause2", 32'(fault_cause), 32'd0);
    checkOutput("mis_addr2",  fault_addr, 32'd0);

    // Misaligned LW
    applyStimulus(LW, 32'h1002, 12'h000, 5'd3);
    checkOutput("mislw_fv",    32'(fault_valid), 32'd1);
    checkOutput("mislw_cause", 32'(fault_cause), 32'd1);
    checkOutput("mislw_addr",  fault_addr, 32'h1002);
    tick();

    // Grant delayed to cycle 5, then timeout with TIMEOUT=4
    applyStimulus(LW, 32'h3000, 12'h000, 5'd9);
    for (int i = 1; i <= 5; i++) begin
      checkOutput($sformatf("to_req_c%0d", i), 32'(bus.mem_req), 32'd1);
      checkOutput($sformatf("to_addr_c%0d", i), bus.mem_addr, 32'h3000);
      if (i == 5) bus.mem_gnt = 1'b1;
      tick();
    end
    bus.mem_gnt = 1'b0;
    for (int i = 6; i <= 9; i++) begin
      checkOutput($sformatf("to_wait_req_c%0d", i), 32'(bus.mem_req), 32'd0);
      checkOutput($sformatf("to_wait_fv_c%0d", i), 32'(fault_valid), 32'd0);
      tick();
    end
    checkOutput("to_fv",     32'(fault_valid), 32'd1);
    checkOutput("to_cause",  32'(fault_cause), 32'd2);
    checkOutput("to_addr",   fault_addr, 32'h3000);
    checkOutput("to_ready",  32'(ready), 32'd0);
    tick();
    checkOutput("to_ready2", 32'(ready), 32'd1);
    checkOutput("to_fv2",    32'(fault_valid), 32'd0);
    checkOutput("to_wbrd",   32'(wb_rd), 32'd8);

    // rvalid in the last WAIT cycle wins over timeout
    applyStimulus(LW, 32'h4000, 12'h000, 5'd10);
    bus.mem_gnt = 1'b1;
    tick();
    bus.mem_gnt = 1'b0;
    tick();
    tick();
    tick();
    checkOutput("win_c5_fv", 32'(fault_valid), 32'd0);
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata = 32'h12345678;
    tick();
    bus.mem_rvalid = 1'b0;
    checkOutput("win_fv",   32'(fault_valid), 32'd0);
    checkOutput("win_wbv",  32'(wb_valid), 32'd1);
    checkOutput("win_data", wb_data, 32'h12345678);
    tick();
    checkOutput("win_ready", 32'(ready), 32'd1);

    // rd = x0: passes through WB without a strobe, writeback registers held
    fastLoad("x0", LW, 32'h100, 12'h000, 5'd0, 32'hCAFEF00D, 32'h100);
    checkOutput("x0_wbv",   32'(wb_valid), 32'd0);
    checkOutput("x0_ready", 32'(ready), 32'd0);
    checkOutput("x0_hold",  wb_data, 32'h12345678);
    checkOutput("x0_rd",    32'(wb_rd), 32'd10);
    tick();
    checkOutput("x0_ready2", 32'(ready), 32'd1);

    // LD_NOP and an undefined op are consumed without effect
    applyStimulus(LD_NOP, 32'h500, 12'h000, 5'd4);
    checkOutput("nop_req",   32'(bus.mem_req), 32'd0);
    checkOutput("nop_ready", 32'(ready), 32'd1);
    checkOutput("nop_fv",    32'(fault_valid), 32'd0);
    applyStimulus(5'd9, 32'h501, 12'h000, 5'd4);
    checkOutput("inv_req",   32'(bus.mem_req), 32'd0);
    checkOutput("inv_fv",    32'(fault_valid), 32'd0);
    checkOutput("inv_ready", 32'(ready), 32'd1);

    // Reset while in WAIT, then stray gnt/rvalid in IDLE
    applyStimulus(LW, 32'h5000, 12'h000, 5'd11);
    bus.mem_gnt = 1'b1;
    tick();
    bus.mem_gnt = 1'b0;
    checkOutput("rw_wait_ready", 32'(ready), 32'd0);
    #2 rst = 1'b1;
    #1;
    checkOutput("rw_req",   32'(bus.mem_req), 32'd0);
    checkOutput("rw_ready", 32'(ready), 32'd1);
    #1 rst = 1'b0;
    bus.mem_rvalid = 1'b1;
    bus.mem_gnt = 1'b1;
    bus.mem_rdata = 32'hBADBAD00;
    tick();
    bus.mem_rvalid = 1'b0;
    bus.mem_gnt = 1'b0;
    checkOutput("rw_wbv",    32'(wb_valid), 32'd0);
    checkOutput("rw_ready2", 32'(ready), 32'd1);
    checkOutput("rw_req2",   32'(bus.mem_req), 32'd0);
    checkOutput("rw_data",   wb_data, 32'd0);
    tick();
    checkOutput("rw_wbv2",   32'(wb_valid), 32'd0);
    fastLoad("fresh", LW, 32'h6000, 12'h010, 5'd12, 32'h0BADF00D, 32'h6010);
    checkOutput("fresh_wbv",  32'(wb_valid), 32'd1);
    checkOutput("fresh_data", wb_data, 32'h0BADF00D);
    checkOutput("fresh_rd",   32'(wb_rd), 32'd12);
    tick();
    checkOutput("fresh_ready", 32'(ready), 32'd1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/load_unit_ctrl.md
# load_unit_ctrl

Multi-cycle load sequencer between the load-immediate decoder and the data-memory port. Accepts one decoded load (op from `LB`/`LH`/`LW`/`LBU`/`LHU`, base register value, 12-bit immediate, rd) and computes the effective address. Runs a request/grant/response transaction on the data-memory bus, then aligns and extends the returned word. Delivers a single-cycle register-file writeback, or a fault pulse on misalignment or memory timeout; the pipeline stalls on `ready`.

## Interface
- `TIMEOUT`, 16: cycles spent in WAIT without `mem_rvalid` before a timeout fault (valid range 2..65535).
- `clk`  in  1  single clock, all state on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  load request; accepted only when `start && ready` in the same cycle.
- `ready`  out  1  high only in IDLE.
- `op`  in  5  load op code from `processor_defines.sv` (`LB`,`LH`,`LW`,`LBU`,`LHU`; anything else, including `LD_NOP`, is a no-op).
- `base`  in  32  rs1 register value.
- `imm`  in  12  signed immediate.
- `rd`  in  5  destination register.
- `mem_req`  out  1  memory request, held until grant.
- `mem_addr`  out  32  word-aligned address `{ea[31:2],2'b00}`, stable while `mem_req`; 0 otherwise.
- `mem_gnt`  in  1  request accepted.
- `mem_rvalid`  in  1  read data valid.
- `mem_rdata`  in  32  read data.
- `wb_valid`  out  1  one-cycle writeback strobe.
- `wb_rd`  out  5  writeback register.
- `wb_data`  out  32  extended load result.
- `fault_valid`  out  1  one-cycle fault strobe.
- `fault_cause`  out  2  01 misaligned, 10 timeout, 00 otherwise.
- `fault_addr`  out  32  effective address of the faulting load.

## Operation
- Effective address: `ea = base + sign_extend(imm)`, 32-bit, carry-out dropped, so wrap-around is legal.
- Alignment rules:
  - `LH`/`LHU` require `ea[0]==0`.
  - `LW` requires `ea[1:0]==0`.
  - `LB`/`LBU` are always aligned.
- States are IDLE, REQ, WAIT, WB, ERR.
- IDLE:
  - Accepted start with a valid aligned op latches `ea`, op and rd, then goes to REQ.
  - Misaligned: latches and goes to ERR.
  - Invalid op: consumed and ignored; stays IDLE with no strobe.
- REQ: `mem_req=1`; on `mem_gnt` goes to WAIT and clears the timeout counter. `mem_rvalid` is ignored in REQ.
- WAIT:
  - On `mem_rvalid`, registers the extracted result and goes to WB.
  - Otherwise the counter increments. Counter reaching `TIMEOUT-1` without `rvalid` goes to ERR with cause 10.
- WB: `wb_valid=1` unless latched rd==0 (x0 writes suppressed; state still passes through WB), then back to IDLE.
- ERR: `fault_valid=1` with cause and `fault_addr`, then back to IDLE.
- Extraction uses byte offset `o=ea[1:0]`:
  - `LB`: sign-extend `mem_rdata[8*o+7:8*o]`.
  - `LBU`: zero-extend the same byte.
  - `LH`: sign-extend `mem_rdata[16*ea[1]+15:16*ea[1]]`.
  - `LHU`: zero-extend the same halfword.
  - `LW`: whole word.
- `wb_rd`/`wb_data` are held between strobes; `fault_cause`/`fault_addr` are valid only with `fault_valid`.

## Timing
- Reset values: state IDLE, `ready=1`, `mem_req=0`, `mem_addr=0`, `wb_valid=0`, `wb_rd=0`, `wb_data=0`, `fault_valid=0`, `fault_cause=0`, `fault_addr=0`.
- All outputs are registered or decoded from state only; no input-to-output combinational path.
- Latency, with start accepted in cycle 0:
  - REQ in cycle 1.
  - If `mem_gnt` arrives in cycle 1, WAIT in cycle 2.
  - If `mem_rvalid` arrives in cycle 2, `wb_valid` in cycle 3; `ready` returns in cycle 4.
  - Minimum start-to-writeback is 3 cycles.
- Misaligned load: `fault_valid` in cycle 1, `ready` in cycle 2.
- Timeout:
  - `fault_valid` asserts `TIMEOUT` cycles after entering WAIT (counter reaches `TIMEOUT-1`, ERR in the next cycle).
  - `rvalid` arriving in the same cycle the counter reaches `TIMEOUT-1` wins; no fault.
- Back-to-back: the next start can be accepted in the first cycle `ready` is high again; no overlap of transactions.
- `start` while busy is ignored; the requester holds `start` until `ready`.
- Reset mid-transaction: immediate abandon, `mem_req` drops asynchronously. Any later `mem_rvalid` or `mem_gnt` seen in IDLE is ignored.

## Test plan
- `LW`, base=0x1000, imm=0x004, gnt in cycle 1, rvalid in cycle 2 with rdata=0xDEADBEEF -> `mem_addr=0x1004`, `wb_valid` in cycle 3, wb_data=0xDEADBEEF.
- `LB` with ea=0x2003, rdata=0x80112233 -> wb_data=0xFFFFFF80; same with `LBU` -> 0x00000080; `LHU` with ea=0x2002 -> 0x00008011.
- `LH`, base=0x0, imm=0xFFF (ea=0xFFFFFFFF) -> fault_valid in cycle 1, cause=01, fault_addr=0xFFFFFFFF, no `mem_req`.
- `LW`, gnt delayed 5 cycles, `TIMEOUT=4`, no rvalid -> `mem_req` held for 5 cycles, fault cause=10 exactly 4 cycles after WAIT entry, `ready` in the following cycle.
- Load with rd=0 and valid data -> `wb_valid` stays 0 and `ready` returns after WB; `LD_NOP` start -> no `mem_req`, `ready` stays 1.
- Reset asserted while in WAIT, then rvalid pulsed -> `mem_req=0`, `wb_valid=0`, `ready=1`; a fresh `LW` then completes normally.
